// File: rtl/sb_pkg.sv
// Shared FSM type and default sizing for the multi-channel scoreboard.
// Defaults follow the FIFO_DEPTH / FIFO_DWIDTH option macros when they are set.
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 8
`endif

`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif

package sb_pkg;

  localparam int SB_DEPTH  = `FIFO_DEPTH;
  localparam int SB_WIDTH  = `FIFO_DWIDTH;
  localparam int SB_NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/sb_channel_tracker.sv
// One channel of the scoreboard: occupancy, magic-packet position and head check.
// Optional macro SB_REARM_EN returns the channel to IDLE after each check instead of DONE.
module sb_channel_tracker
   import sb_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int WIDTH  = SB_WIDTH,
   parameter int CNTWID = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] data_out,
   output logic             data_out_vld,
   output logic             prop_signal
);

   localparam logic [CNTWID-1:0] DEPTH_C = CNTWID'(DEPTH);
   localparam logic [CNTWID-1:0] ONE_C   = CNTWID'(1);

   sb_state_e         state_q, state_d;
   logic [CNTWID-1:0] occ_q, occ_d;
   logic [CNTWID-1:0] pos_q, pos_d;
   logic [WIDTH-1:0]  magic_q, magic_d;
   logic              push_ok, pop_ok, capture, exit_hit;

   always_comb begin
      push_ok  = push && (occ_q < DEPTH_C);
      pop_ok   = pop && (occ_q != '0);
      capture  = (state_q == IDLE) && start && push_ok;
      exit_hit = (state_q == TRACK) && (pos_q == ONE_C) && pop_ok;
      occ_d    = occ_q;
      if (push_ok && !pop_ok) begin
         occ_d = occ_q + ONE_C;
      end else if (!push_ok && pop_ok) begin
         occ_d = occ_q - ONE_C;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (capture) state_d = TRACK;
         end
         TRACK: begin
            if (exit_hit) begin
`ifdef SB_REARM_EN
               state_d = IDLE;
`else
               state_d = DONE;
`endif
            end
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Capture position is taken from occ_d so a same-cycle pop counts as ahead of the magic packet.
   always_comb begin
      pos_d   = pos_q;
      magic_d = magic_q;
      if (capture) begin
         pos_d   = occ_d;
         magic_d = data_in;
      end else if ((state_q == TRACK) && pop_ok) begin
         pos_d = pos_q - ONE_C;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q   <= '0;
         pos_q   <= '0;
         magic_q <= '0;
      end else begin
         occ_q   <= occ_d;
         pos_q   <= pos_d;
         magic_q <= magic_d;
      end
   end

   always_comb begin
      data_out_vld = exit_hit;
      prop_signal  = !exit_hit || (data_out == magic_q);
   end

endmodule

// File: rtl/multi_channel_scoreboard.sv
// Multi-channel data-integrity scoreboard: per-channel trackers plus shared error latch and check counter.
// Optional macro SB_REARM_EN lets every channel re-capture after a completed check.
module multi_channel_scoreboard
   import sb_pkg::*;
#(
   parameter int NUM_CH = SB_NUM_CH,
   parameter int DEPTH  = SB_DEPTH,
   parameter int WIDTH  = SB_WIDTH,
   parameter int CNTWID = $clog2(DEPTH) + 1,
   parameter int CHKWID = 8,
   parameter int CHWID  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       push,
   input  logic [NUM_CH-1:0]       pop,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH*WIDTH-1:0] flat_data_in,
   input  logic [NUM_CH*WIDTH-1:0] flat_data_out,
   output logic [NUM_CH-1:0]       data_out_vld,
   output logic [NUM_CH-1:0]       prop_signal,
   output logic                    err_sticky,
   output logic [CHWID-1:0]        err_ch,
   output logic [CHKWID-1:0]       check_cnt
);

   logic [NUM_CH-1:0] fail;
   logic              err_sticky_q, err_sticky_d;
   logic [CHWID-1:0]  err_ch_q, err_ch_d;
   logic [CHKWID-1:0] check_cnt_q, check_cnt_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sb_channel_tracker #(
         .DEPTH  (DEPTH),
         .WIDTH  (WIDTH),
         .CNTWID (CNTWID)
      ) u_trk (
         .clk          (clk),
         .rst          (rst),
         .push         (push[i]),
         .pop          (pop[i]),
         .start        (start[i]),
         .data_in      (flat_data_in[i*WIDTH +: WIDTH]),
         .data_out     (flat_data_out[i*WIDTH +: WIDTH]),
         .data_out_vld (data_out_vld[i]),
         .prop_signal  (prop_signal[i])
      );
   end

   assign fail = data_out_vld & ~prop_signal;

   // Descending scan so the lowest failing channel is the one left in err_ch_d.
   always_comb begin
      err_sticky_d = err_sticky_q;
      err_ch_d     = err_ch_q;
      check_cnt_d  = check_cnt_q;
      if (!err_sticky_q && (fail != '0)) begin
         err_sticky_d = 1'b1;
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fail[i]) err_ch_d = CHWID'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (data_out_vld[i] && (check_cnt_d != '1)) begin
            check_cnt_d = check_cnt_d + CHKWID'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_sticky_q <= 1'b0;
         err_ch_q     <= '0;
         check_cnt_q  <= '0;
      end else begin
         err_sticky_q <= err_sticky_d;
         err_ch_q     <= err_ch_d;
         check_cnt_q  <= check_cnt_d;
      end
   end

   assign err_sticky = err_sticky_q;
   assign err_ch     = err_ch_q;
   assign check_cnt  = check_cnt_q;

endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// Directed bench for multi_channel_scoreboard: magic packets queued at capture, checked at exit.
// Expectations for the second capture on ch0 follow SB_REARM_EN.
module tb_multi_channel_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  push, pop, start;
   logic [31:0] flat_data_in, flat_data_out;
   logic [3:0]  data_out_vld, prop_signal;
   logic        err_sticky;
   logic [1:0]  err_ch;
   logic [7:0]  check_cnt;

   typedef struct {
      int         ch;
      logic [7:0] magic;
   } sb_ent_t;

   sb_ent_t    sb [$];
   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] exp_cnt;
   logic       exp_err;
   logic [1:0] exp_ch;

`ifdef SB_REARM_EN
   localparam logic [3:0] REARM_EV = 4'b0001;
`else
   localparam logic [3:0] REARM_EV = 4'b0000;
`endif

   always #5 clk = ~clk;

   multi_channel_scoreboard dut (
      .clk           (clk),
      .rst           (rst),
      .push          (push),
      .pop           (pop),
      .start         (start),
      .flat_data_in  (flat_data_in),
      .flat_data_out (flat_data_out),
      .data_out_vld  (data_out_vld),
      .prop_signal   (prop_signal),
      .err_sticky    (err_sticky),
      .err_ch        (err_ch),
      .check_cnt     (check_cnt)
   );

   function automatic logic [31:0] slot(input int c, input logic [7:0] v);
      slot = {24'd0, v} << (8 * c);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_capture(input int c, input logic [7:0] v);
      sb_ent_t e;
      e.ch    = c;
      e.magic = v;
      sb.push_back(e);
   endtask

   // One clock cycle: drive at the falling edge, check combinational outputs, then registered ones.
   task automatic cyc(input logic [3:0] pu, input logic [3:0] po, input logic [3:0] st,
                      input logic [31:0] din, input logic [31:0] dout, input logic [3:0] ev);
      logic [3:0] ep;
      logic [3:0] fl;
      logic [7:0] m;
      bit         found;
      push = pu; pop = po; start = st;
      flat_data_in = din; flat_data_out = dout;
      #1;
      ep = 4'hF;
      fl = 4'h0;
      for (int c = 0; c < 4; c++) begin
         if (ev[c]) begin
            found = 1'b0;
            m     = 8'h00;
            for (int k = 0; k < sb.size(); k++) begin
               if (!found && sb[k].ch == c) begin
                  m     = sb[k].magic;
                  found = 1'b1;
                  sb.delete(k);
               end
            end
            chk("sb_entry", 32'(found), 32'd1);
            if (found && dout[c*8 +: 8] != m) begin
               ep[c] = 1'b0;
               fl[c] = 1'b1;
            end
         end
      end
      chk("data_out_vld", 32'(data_out_vld), 32'(ev));
      chk("prop_signal", 32'(prop_signal), 32'(ep));
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         if (ev[c] && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
      if (!exp_err && fl != 4'h0) begin
         exp_err = 1'b1;
         for (int c = 3; c >= 0; c--) begin
            if (fl[c]) exp_ch = 2'(c);
         end
      end
      chk("check_cnt", 32'(check_cnt), 32'(exp_cnt));
      chk("err_sticky", 32'(err_sticky), 32'(exp_err));
      chk("err_ch", 32'(err_ch), 32'(exp_ch));
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before the next clock edge.
   task automatic do_reset();
      push = '0; pop = '0; start = '0;
      flat_data_in = '0; flat_data_out = '0;
      #2 rst = 1'b0;
      #1;
      chk("rst_vld", 32'(data_out_vld), 32'h0);
      chk("rst_prop", 32'(prop_signal), 32'hF);
      chk("rst_err", 32'(err_sticky), 32'h0);
      chk("rst_err_ch", 32'(err_ch), 32'h0);
      chk("rst_cnt", 32'(check_cnt), 32'h0);
      sb.delete();
      exp_cnt = 8'd0;
      exp_err = 1'b0;
      exp_ch  = 2'd0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      push = '0; pop = '0; start = '0;
      flat_data_in = '0; flat_data_out = '0;
      exp_cnt = 8'd0; exp_err = 1'b0; exp_ch = 2'd0;
      @(negedge clk);
      chk("init_vld", 32'(data_out_vld), 32'h0);
      chk("init_prop", 32'(prop_signal), 32'hF);
      chk("init_err", 32'(err_sticky), 32'h0);
      chk("init_err_ch", 32'(err_ch), 32'h0);
      chk("init_cnt", 32'(check_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // ch0: two packets ahead of the magic one, passing check on the third pop
      cyc(4'b0001, 4'b0000, 4'b0000, slot(0, 8'h11), 32'h0, 4'b0000);
      cyc(4'b0001, 4'b0000, 4'b0000, slot(0, 8'h22), slot(0, 8'h11), 4'b0000);
      expect_capture(0, 8'h33);
      cyc(4'b0001, 4'b0000, 4'b0001, slot(0, 8'h33), slot(0, 8'h11), 4'b0000);
      cyc(4'b0000, 4'b0001, 4'b0000, 32'h0, slot(0, 8'h11), 4'b0000);
      cyc(4'b0000, 4'b0001, 4'b0000, 32'h0, slot(0, 8'h22), 4'b0000);
      cyc(4'b0000, 4'b0001, 4'b0000, 32'h0, slot(0, 8'h33), 4'b0001);

      // ch1: corrupted head on exit sets the sticky error
      cyc(4'b0010, 4'b0000, 4'b0000, slot(1, 8'h10), 32'h0, 4'b0000);
      expect_capture(1, 8'h33);
      cyc(4'b0010, 4'b0000, 4'b0010, slot(1, 8'h33), slot(1, 8'h10), 4'b0000);
      cyc(4'b0000, 4'b0010, 4'b0000, 32'h0, slot(1, 8'h10), 4'b0000);
      cyc(4'b0000, 4'b0010, 4'b0000, 32'h0, slot(1, 8'h34), 4'b0010);

      // ch2: capture with a simultaneous pop, then a later failure that must not move err_ch
      cyc(4'b0100, 4'b0000, 4'b0000, slot(2, 8'h55), 32'h0, 4'b0000);
      expect_capture(2, 8'h66);
      cyc(4'b0100, 4'b0100, 4'b0100, slot(2, 8'h66), slot(2, 8'h55), 4'b0000);
      cyc(4'b0000, 4'b0100, 4'b0000, 32'h0, slot(2, 8'h67), 4'b0100);

      // ch3: start on a full FIFO is ignored; a later capture lands at the right position
      for (int i = 0; i < 8; i++) cyc(4'b1000, 4'b0000, 4'b0000, slot(3, 8'(i)), 32'h0, 4'b0000);
      cyc(4'b1000, 4'b0000, 4'b1000, slot(3, 8'h99), 32'h0, 4'b0000);
      for (int i = 0; i < 7; i++) cyc(4'b0000, 4'b1000, 4'b0000, 32'h0, 32'h0, 4'b0000);
      expect_capture(3, 8'hAA);
      cyc(4'b1000, 4'b0000, 4'b1000, slot(3, 8'hAA), 32'h0, 4'b0000);
      cyc(4'b0000, 4'b1000, 4'b0000, 32'h0, 32'h0, 4'b0000);
      cyc(4'b0000, 4'b1000, 4'b0000, 32'h0, slot(3, 8'hAA), 4'b1000);

      // reset, then put ch0 in TRACK with pos=2 and reset again mid-track
      do_reset();
      cyc(4'b0001, 4'b0000, 4'b0000, slot(0, 8'h01), 32'h0, 4'b0000);
      expect_capture(0, 8'h02);
      cyc(4'b0001, 4'b0000, 4'b0001, slot(0, 8'h02), slot(0, 8'h01), 4'b0000);
      do_reset();

      // fresh captures on ch0 and ch3, simultaneous failing exits
      expect_capture(0, 8'h77);
      expect_capture(3, 8'h88);
      cyc(4'b1001, 4'b0000, 4'b1001, slot(0, 8'h77) | slot(3, 8'h88), 32'h0, 4'b0000);
      cyc(4'b0000, 4'b1001, 4'b0000, 32'h0, slot(0, 8'h70) | slot(3, 8'h80), 4'b1001);

      // second capture on ch0 behind three queued packets
      cyc(4'b0001, 4'b0000, 4'b0000, slot(0, 8'h01), 32'h0, 4'b0000);
      cyc(4'b0001, 4'b0000, 4'b0000, slot(0, 8'h02), slot(0, 8'h01), 4'b0000);
      cyc(4'b0001, 4'b0000, 4'b0000, slot(0, 8'h03), slot(0, 8'h01), 4'b0000);
`ifdef SB_REARM_EN
      expect_capture(0, 8'h5A);
`endif
      cyc(4'b0001, 4'b0000, 4'b0001, slot(0, 8'h5A), slot(0, 8'h01), 4'b0000);
      cyc(4'b0000, 4'b0001, 4'b0000, 32'h0, slot(0, 8'h01), 4'b0000);
      cyc(4'b0000, 4'b0001, 4'b0000, 32'h0, slot(0, 8'h02), 4'b0000);
      cyc(4'b0000, 4'b0001, 4'b0000, 32'h0, slot(0, 8'h03), 4'b0000);
      cyc(4'b0000, 4'b0001, 4'b0000, 32'h0, slot(0, 8'h5A), REARM_EV);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
